// File: rtl/count_seq_pkg.sv
// Shared types and default widths for the count sequencer.
package count_seq_pkg;

  localparam int DEF_LEN_W = 8;  // width of run length / steps remaining
  localparam int DEF_PER_W = 4;  // width of swap period; period 0 disables swapping

  // Sequencer states. PAUSE is only reachable when the pause feature is built in.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    SWAP  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/count_sequencer_swap_timer.sv
// Period counter for the sequencer: counts enable steps since the last swap
// and flags the step on which the next swap is due.
module swap_timer
  import count_seq_pkg::*;
#(
  parameter int PER_W = DEF_PER_W
) (
  input  logic             clock,
  input  logic             reset,   // synchronous, active-low
  input  logic             clear,
  input  logic             inc,
  input  logic [PER_W-1:0] period,
  output logic             hit
);

  logic [PER_W-1:0] count;

  // Step counter: clear wins over increment so a swap restarts the period cleanly.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + PER_W'(1);
    end
  end

  // A zero period never hits, which is how swapping is switched off.
  assign hit = (period != '0) && (count == period - PER_W'(1));

endmodule

// File: rtl/count_sequencer.sv
// Sequencer driving the up/down counter's enable and swap inputs from a
// programmed run of 'length' steps with a swap pulse every 'swap_period' steps.
// Optional feature: define COUNT_SEQ_PAUSE_EN to add the 'pause' input and PAUSE state.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int PER_W = DEF_PER_W
) (
  input  logic             clock,
  input  logic             reset,        // synchronous, active-low
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  input  logic [PER_W-1:0] swap_period,
  input  logic             abort,
`ifdef COUNT_SEQ_PAUSE_EN
  input  logic             pause,
`endif
  output logic             enable,
  output logic             swap,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] steps_left
);

  state_t           state;
  state_t           next_state;
  logic [PER_W-1:0] period_q;
  logic             pause_req;
  logic             hit;
  logic             last_step;
  logic             timer_clear;
  logic             timer_inc;

`ifdef COUNT_SEQ_PAUSE_EN
  assign pause_req = pause;
`else
  // Without the feature PAUSE can never be entered and its logic folds away.
  assign pause_req = 1'b0;
`endif

  assign last_step = (steps_left == LEN_W'(1));

  // Next-state decode; priority abort > pause > completion > swap > step.
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = (length == '0) ? DONE : RUN;
      end
      RUN: begin
        if (abort)          next_state = IDLE;
        else if (pause_req) next_state = PAUSE;
        else if (last_step) next_state = DONE;
        else if (hit)       next_state = SWAP;
      end
      SWAP: begin
        next_state = abort ? IDLE : RUN;
      end
      PAUSE: begin
        if (abort)           next_state = IDLE;
        else if (!pause_req) next_state = RUN;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Period counter restarts whenever the run leaves RUN other than to pause.
  assign timer_clear = (next_state == IDLE) || (next_state == DONE) || (next_state == SWAP);
  assign timer_inc   = (state == RUN) && (next_state == RUN);

  swap_timer #(.PER_W(PER_W)) u_swap_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .inc    (timer_inc),
    .period (period_q),
    .hit    (hit)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Run parameters and steps remaining; each RUN cycle that is not paused consumes a step.
  always_ff @(posedge clock) begin
    if (!reset) begin
      steps_left <= '0;
      period_q   <= '0;
    end else if (state == IDLE) begin
      if (start && (length != '0)) begin
        steps_left <= length;
        period_q   <= swap_period;
      end
    end else if (next_state == IDLE) begin
      steps_left <= '0;
    end else if ((state == RUN) && (next_state != PAUSE)) begin
      steps_left <= steps_left - LEN_W'(1);
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      enable <= 1'b0;
      swap   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      enable <= (next_state == RUN);
      swap   <= (next_state == SWAP);
      busy   <= (next_state != IDLE);
      done   <= (next_state == DONE);
    end
  end

endmodule
